m00_exit_ar_burst_splitter: RTL and testbench

// - Read-side sequencer in front of the m00 exit stage (AXI4 256-bit slave side to AXI3 master side).
// - Splits each AXI4 INCR read burst (ARLEN up to 255) into AXI3 sub-bursts of at most 16 beats.
// - Tracks outstanding sub-bursts in an in-order FIFO.
// - On R return: restores RID and suppresses RLAST on every sub-burst except the final one.

---
 rtl/m00_exit_ar_burst_splitter_if.sv | 56 +++++
 rtl/m00_exit_ar_burst_splitter.sv | 138 +++++++++++++
 tb/tb_m00_exit_ar_burst_splitter.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/m00_exit_ar_burst_splitter_if.sv
// Read-side bus bundle between the AXI4 slave port and the AXI3 master port of the m00 exit stage.
// Latency: none, wires only.
// Backpressure: carries arvalid/arready and rvalid/rready on both sides unchanged.
interface m00_exit_ar_burst_splitter_if #(
    parameter int ADDR_W = 33,
    parameter int ID_W   = 3,
    parameter int DATA_W = 256
);
    logic [ADDR_W-1:0] s_axi_araddr;
    logic [ID_W-1:0]   s_axi_arid;
    logic [7:0]        s_axi_arlen;
    logic              s_axi_arvalid;
    logic              s_axi_arready;

    logic [ADDR_W-1:0] m_axi_araddr;
    logic [3:0]        m_axi_arlen;
    logic              m_axi_arvalid;
    logic              m_axi_arready;

    logic [DATA_W-1:0] m_axi_rdata;
    logic [1:0]        m_axi_rresp;
    logic              m_axi_rlast;
    logic              m_axi_rvalid;
    logic              m_axi_rready;

    logic [DATA_W-1:0] s_axi_rdata;
    logic [ID_W-1:0]   s_axi_rid;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rlast;
    logic              s_axi_rvalid;
    logic              s_axi_rready;

    // Splitter side.
    modport slave (
        input  s_axi_araddr, s_axi_arid, s_axi_arlen, s_axi_arvalid,
        output s_axi_arready,
        output m_axi_araddr, m_axi_arlen, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready,
        output s_axi_rdata, s_axi_rid, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        input  s_axi_rready
    );

    // Environment side: AXI4 master plus AXI3 slave.
    modport master (
        output s_axi_araddr, s_axi_arid, s_axi_arlen, s_axi_arvalid,
        input  s_axi_arready,
        input  m_axi_araddr, m_axi_arlen, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready,
        input  s_axi_rdata, s_axi_rid, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        output s_axi_rready
    );
endinterface

// File: rtl/m00_exit_ar_burst_splitter.sv
// Splits AXI4 INCR read bursts (up to 256 beats) into AXI3 sub-bursts of <=16 beats, restores RID/RLAST on return.
// Latency: first sub-burst AR one cycle after AXI4 AR acceptance; R path is combinational.
// Backpressure: AR issue stalls while MAX_OUTST sub-bursts are outstanding; R stalls (rready=0) while none are.
module m00_exit_ar_burst_splitter #(
    parameter int ADDR_W    = 33,
    parameter int ID_W      = 3,
    parameter int DATA_W    = 256,
    parameter int MAX_OUTST = 8
) (
    input  logic aclk,
    input  logic aresetn,
    m00_exit_ar_burst_splitter_if.slave bus
);
    localparam int PTR_W = $clog2(MAX_OUTST);

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [ID_W-1:0]   id;
    logic [8:0]        rem;
    logic              arready;
    logic              arvalid;
    logic [3:0]        sub_len;
    logic [4:0]        beats;
    logic [ADDR_W-1:0] step;
    logic              sub_last;
    logic              s_ar_hs;
    logic              m_ar_hs;

    logic [ID_W-1:0]   fifo_id   [MAX_OUTST];
    logic              fifo_last [MAX_OUTST];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              m_rready;

    assign s_ar_hs  = bus.s_axi_arvalid & arready;
    assign m_ar_hs  = arvalid & bus.m_axi_arready;
    assign sub_last = (rem <= 9'd16);
    assign beats    = {1'b0, sub_len} + 5'd1;
    assign step     = {{(ADDR_W-10){1'b0}}, beats, 5'b0};

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state: accept one AXI4 AR, then stay in ISSUE until its final sub-burst handshakes.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (s_ar_hs) state_nxt = ISSUE;
            ISSUE:   if (m_ar_hs && sub_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: present the current sub-burst only when the tracking FIFO can take it.
    // A presented AR cannot lose its slot, because the FIFO only fills through its own handshake.
    always_comb begin
        arvalid = 1'b0;
        sub_len = 4'd0;
        if (state == ISSUE) begin
            arvalid = !full;
            sub_len = sub_last ? (rem[3:0] - 4'd1) : 4'd15;
        end
    end

    // Burst context: capture on acceptance, advance address/remaining beats per issued sub-burst.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            addr    <= '0;
            id      <= '0;
            rem     <= '0;
            arready <= 1'b0;
        end else begin
            arready <= (state_nxt == IDLE);
            if (s_ar_hs) begin
                addr <= bus.s_axi_araddr;
                id   <= bus.s_axi_arid;
                rem  <= {1'b0, bus.s_axi_arlen} + 9'd1;
            end else if (m_ar_hs) begin
                addr <= addr + step;
                rem  <= rem - {4'b0, beats};
            end
        end
    end

    assign push     = m_ar_hs;
    assign m_rready = bus.s_axi_rready & !empty;
    assign pop      = bus.m_axi_rvalid & m_rready & bus.m_axi_rlast;
    assign full     = (count == (PTR_W+1)'(MAX_OUTST));
    assign empty    = (count == '0);

    // Outstanding sub-burst storage; entries are only read while valid, so no reset is needed.
    always_ff @(posedge aclk) begin
        if (push) begin
            fifo_id[wr_ptr]   <= id;
            fifo_last[wr_ptr] <= sub_last;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign bus.s_axi_arready = arready;
    assign bus.m_axi_araddr  = addr;
    assign bus.m_axi_arlen   = sub_len;
    assign bus.m_axi_arvalid = arvalid;

    assign bus.m_axi_rready  = m_rready;
    assign bus.s_axi_rvalid  = bus.m_axi_rvalid & !empty;
    assign bus.s_axi_rdata   = bus.m_axi_rdata;
    assign bus.s_axi_rresp   = bus.m_axi_rresp;
    assign bus.s_axi_rid     = fifo_id[rd_ptr];
    assign bus.s_axi_rlast   = bus.m_axi_rlast & fifo_last[rd_ptr];
endmodule

// File: tb/tb_m00_exit_ar_burst_splitter.sv
// Bench for the read burst splitter: random AXI4 bursts against a queue-based reference model.
// Latency: AR and R expectations are queued at AXI4 AR acceptance and popped by independent monitors.
// Backpressure: randomised m_axi_arready, m_axi_rvalid and s_axi_rready, plus directed stall and reset cases.
module tb_m00_exit_ar_burst_splitter;
    localparam int ADDR_W    = 33;
    localparam int ID_W      = 3;
    localparam int DATA_W    = 256;
    localparam int MAX_OUTST = 8;
    localparam int BIG       = 1000000;

    logic aclk    = 1'b0;
    logic aresetn = 1'b1;
    always #5 aclk = ~aclk;

    m00_exit_ar_burst_splitter_if #(.ADDR_W(ADDR_W), .ID_W(ID_W), .DATA_W(DATA_W)) bus ();

    m00_exit_ar_burst_splitter #(
        .ADDR_W(ADDR_W), .ID_W(ID_W), .DATA_W(DATA_W), .MAX_OUTST(MAX_OUTST)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .bus(bus)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [3:0]        len;
    } ar_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [ID_W-1:0]   id;
        logic              last;
    } beat_t;

    ar_t   ar_exp[$];
    beat_t r_exp[$];
    ar_t   slave_q[$];

    int n_cmp    = 0;
    int n_fail   = 0;
    int m_ar_cnt = 0;
    int r_budget = BIG;
    bit ar_rand  = 1'b1;
    bit rr_rand  = 1'b0;

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W/32; i++)
            d[i*32 +: 32] = a[31:0] + 32'(i) * 32'h0101_0101 + {31'b0, a[32]};
        return d;
    endfunction

    function automatic logic [1:0] resp_of(input logic [ADDR_W-1:0] a);
        return a[6:5] ^ a[8:7];
    endfunction

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bad(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference model: an accepted burst of N beats becomes ceil(N/16) sub-bursts of 16 beats (last one shorter),
    // and N returned beats with consecutive addresses, the original id, and last only on beat N.
    task automatic model_burst(input logic [ADDR_W-1:0] a, input logic [ID_W-1:0] i, input logic [7:0] l);
        int total;
        int n;
        ar_t   e;
        beat_t bt;
        total = int'(l) + 1;
        for (int b = 0; b < total; b += 16) begin
            n      = (total - b > 16) ? 16 : total - b;
            e.addr = a + ADDR_W'(b * 32);
            e.len  = 4'(n - 1);
            ar_exp.push_back(e);
        end
        for (int k = 0; k < total; k++) begin
            bt.addr = a + ADDR_W'(k * 32);
            bt.id   = i;
            bt.last = (k == total - 1);
            r_exp.push_back(bt);
        end
    endtask

    // Stimulus-side monitor: every accepted AXI4 AR enters the model.
    initial forever begin
        @(negedge aclk);
        if (aresetn && bus.s_axi_arvalid && bus.s_axi_arready)
            model_burst(bus.s_axi_araddr, bus.s_axi_arid, bus.s_axi_arlen);
    end

    // AXI3 AR monitor: compare each issued sub-burst and hand it to the slave model.
    initial begin : ar_mon
        ar_t e;
        ar_t got;
        forever begin
            @(negedge aclk);
            if (aresetn && bus.m_axi_arvalid && bus.m_axi_arready) begin
                m_ar_cnt++;
                got.addr = bus.m_axi_araddr;
                got.len  = bus.m_axi_arlen;
                slave_q.push_back(got);
                if (ar_exp.size() == 0) bad("ar_unexpected");
                else begin
                    e = ar_exp.pop_front();
                    chk("ar_addr", DATA_W'(got.addr), DATA_W'(e.addr));
                    chk("ar_len", DATA_W'(got.len), DATA_W'(e.len));
                end
            end
        end
    end

    // AXI4 R monitor: compare each delivered beat in order.
    initial begin : r_mon
        beat_t bt;
        forever begin
            @(negedge aclk);
            if (aresetn && bus.s_axi_rvalid && bus.s_axi_rready) begin
                if (r_exp.size() == 0) bad("r_unexpected");
                else begin
                    bt = r_exp.pop_front();
                    chk("r_data", bus.s_axi_rdata, pat(bt.addr));
                    chk("r_id", DATA_W'(bus.s_axi_rid), DATA_W'(bt.id));
                    chk("r_resp", DATA_W'(bus.s_axi_rresp), DATA_W'(resp_of(bt.addr)));
                    chk("r_last", DATA_W'(bus.s_axi_rlast), DATA_W'(bt.last));
                end
            end
        end
    end

    // AXI3 AR ready driver.
    initial begin
        bus.m_axi_arready = 1'b0;
        forever begin
            @(posedge aclk); #1;
            bus.m_axi_arready = ar_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // AXI4 R ready driver.
    initial begin
        bus.s_axi_rready = 1'b1;
        forever begin
            @(posedge aclk); #1;
            bus.s_axi_rready = rr_rand ? ($urandom_range(0, 1) != 0) : 1'b1;
        end
    end

    // AXI3 slave memory model: returns sub-bursts in order, holding valid until accepted.
    initial begin : r_drv
        bit  hs;
        bit  active;
        int  beat;
        ar_t cur;
        active = 1'b0;
        beat   = 0;
        cur.addr = '0;
        cur.len  = '0;
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rdata  = '0;
        bus.m_axi_rresp  = '0;
        bus.m_axi_rlast  = 1'b0;
        forever begin
            @(negedge aclk);
            hs = bus.m_axi_rvalid && bus.m_axi_rready;
            @(posedge aclk); #1;
            if (!aresetn) begin
                active = 1'b0;
                bus.m_axi_rvalid = 1'b0;
            end else begin
                if (hs) begin
                    if (beat == int'(cur.len)) active = 1'b0;
                    else beat++;
                end
                if (!active && slave_q.size() > 0 && r_budget > 0) begin
                    cur    = slave_q.pop_front();
                    active = 1'b1;
                    beat   = 0;
                    r_budget--;
                end
                if (active) begin
                    if (!(bus.m_axi_rvalid && !hs))
                        bus.m_axi_rvalid = ($urandom_range(0, 3) != 0);
                    bus.m_axi_rdata = pat(cur.addr + ADDR_W'(beat * 32));
                    bus.m_axi_rresp = resp_of(cur.addr + ADDR_W'(beat * 32));
                    bus.m_axi_rlast = (beat == int'(cur.len));
                end else begin
                    bus.m_axi_rvalid = 1'b0;
                end
            end
        end
    end

    task automatic wait_ar_accept();
        int  t;
        bit  done;
        t    = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge aclk);
            if (bus.s_axi_arvalid && bus.s_axi_arready) done = 1'b1;
            else if (++t > 20000) begin
                bad("ar_accept_timeout");
                done = 1'b1;
            end
        end
        @(posedge aclk); #1;
        bus.s_axi_arvalid = 1'b0;
    endtask

    task automatic issue_ar(input logic [ADDR_W-1:0] a, input logic [ID_W-1:0] i, input logic [7:0] l);
        @(posedge aclk); #1;
        bus.s_axi_araddr  = a;
        bus.s_axi_arid    = i;
        bus.s_axi_arlen   = l;
        bus.s_axi_arvalid = 1'b1;
        wait_ar_accept();
    endtask

    task automatic issue_random(input logic [ID_W-1:0] i);
        logic [7:0]        l;
        logic [20:0]       page;
        int                off;
        l    = 8'($urandom_range(0, 255));
        page = 21'($urandom);
        off  = $urandom_range(0, (4096 - (int'(l) + 1) * 32) / 32) * 32;
        issue_ar({page, 12'(off)}, i, l);
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while ((r_exp.size() > 0 || ar_exp.size() > 0) && t < 20000) begin
            @(posedge aclk);
            t++;
        end
        repeat (3) @(posedge aclk);
        chk({name, "_r_left"}, DATA_W'(r_exp.size()), '0);
        chk({name, "_ar_left"}, DATA_W'(ar_exp.size()), '0);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_s_arready"}, DATA_W'(bus.s_axi_arready), '0);
        chk({name, "_m_arvalid"}, DATA_W'(bus.m_axi_arvalid), '0);
        chk({name, "_m_araddr"}, DATA_W'(bus.m_axi_araddr), '0);
        chk({name, "_m_arlen"}, DATA_W'(bus.m_axi_arlen), '0);
        chk({name, "_s_rvalid"}, DATA_W'(bus.s_axi_rvalid), '0);
        chk({name, "_m_rready"}, DATA_W'(bus.m_axi_rready), '0);
    endtask

    initial begin : main
        int base;
        int t;
        bus.s_axi_araddr  = '0;
        bus.s_axi_arid    = '0;
        bus.s_axi_arlen   = '0;
        bus.s_axi_arvalid = 1'b0;

        #1 aresetn = 1'b0;
        #2 chk_reset_outputs("reset");
        repeat (2) @(posedge aclk);
        #2 aresetn = 1'b1;
        @(posedge aclk); #3;
        chk("idle_arready", DATA_W'(bus.s_axi_arready), DATA_W'(1));

        // Single beat, one sub-burst.
        issue_ar(33'h1000, 3'd5, 8'd0);
        wait_drain("len0");

        // Full 256-beat burst: 16 sub-bursts.
        issue_ar(33'h0, 3'd0, 8'd255);
        wait_drain("len255");

        // 17 beats: 16 + 1.
        issue_ar(33'h5000, 3'd7, 8'd16);
        wait_drain("len16");

        // Outstanding limit with R held back and AR always ready.
        ar_rand  = 1'b0;
        r_budget = 0;
        base     = m_ar_cnt;
        issue_ar(33'h0, 3'd3, 8'd255);
        bus.s_axi_araddr  = 33'h2000;
        bus.s_axi_arid    = 3'd4;
        bus.s_axi_arlen   = 8'd255;
        bus.s_axi_arvalid = 1'b1;
        repeat (40) @(posedge aclk);
        #3;
        chk("outst_ar_count", DATA_W'(m_ar_cnt - base), DATA_W'(MAX_OUTST));
        chk("outst_arvalid", DATA_W'(bus.m_axi_arvalid), '0);
        chk("outst_s_arready", DATA_W'(bus.s_axi_arready), '0);
        r_budget = 1;
        repeat (80) @(posedge aclk);
        #3;
        chk("outst_ar_count_after_drain", DATA_W'(m_ar_cnt - base), DATA_W'(MAX_OUTST + 1));
        chk("outst_arvalid_after_drain", DATA_W'(bus.m_axi_arvalid), '0);
        r_budget = BIG;
        wait_ar_accept();
        wait_drain("outst");
        ar_rand = 1'b1;

        // Back-to-back bursts with ids 1 and 2 under random R backpressure.
        rr_rand = 1'b1;
        issue_random(3'd1);
        issue_random(3'd2);
        wait_drain("b2b");

        for (int n = 0; n < 10; n++) issue_random(3'($urandom));
        wait_drain("random");

        // Reset with three sub-bursts outstanding.
        rr_rand  = 1'b0;
        ar_rand  = 1'b0;
        r_budget = 0;
        base     = m_ar_cnt;
        issue_ar(33'h4000, 3'd6, 8'd255);
        t = 0;
        while (m_ar_cnt < base + 3 && t < 2000) begin
            @(posedge aclk);
            t++;
        end
        if (t >= 2000) bad("reset_setup_timeout");
        #2 aresetn = 1'b0;
        #1 chk_reset_outputs("midreset");
        ar_exp.delete();
        r_exp.delete();
        slave_q.delete();
        repeat (3) @(posedge aclk);
        #2 aresetn = 1'b1;
        @(posedge aclk); #3;
        chk("postreset_arready", DATA_W'(bus.s_axi_arready), DATA_W'(1));
        chk("postreset_arvalid", DATA_W'(bus.m_axi_arvalid), '0);
        chk("postreset_rready", DATA_W'(bus.m_axi_rready), '0);
        r_budget = BIG;
        ar_rand  = 1'b1;
        rr_rand  = 1'b1;
        issue_ar(33'h1_FFFF_F000, 3'd2, 8'd127);
        for (int n = 0; n < 3; n++) issue_random(3'($urandom));
        wait_drain("postreset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end
endmodule
